// File: rtl/mipi_lane_deskew_aligner.sv
// N-lane HS byte aligner: per-lane SoT hunt at any bit offset, deskew FIFOs, lockstep release.
// Optional SYNC_1BIT_TOL_EN: hunt also accepts a sync candidate with exactly one bit in error.
module mipi_lane_deskew_aligner #(
  parameter int unsigned LANES        = 2,
  parameter int unsigned SKEW_DEPTH   = 4,
  parameter logic [7:0]  SYNC_BYTE    = 8'hB8,
  parameter int unsigned SYNC_TIMEOUT = 16
) (
  input  logic                 sync_mipi_clk_2,
  input  logic                 reset,
  input  logic                 stop,
  input  logic [4*LANES-1:0]   nib_i,
  output logic [8*LANES-1:0]   byte_o,
  output logic                 byte_valid,
  output logic [LANES-1:0]     lane_locked,
  output logic                 locked,
  output logic                 sync_err
);

  localparam int unsigned AW = $clog2(SKEW_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(SYNC_TIMEOUT) + 1;

  typedef enum logic [1:0] {ST_HUNT, ST_ALIGN, ST_STREAM, ST_ERROR} state_t;

  logic [15:0]      r_win    [LANES];
  logic [15:0]      w_win_nx [LANES];
  logic [1:0]       r_off    [LANES];
  logic [1:0]       w_moff   [LANES];
  logic [7:0]       w_wdata  [LANES];
  logic [7:0]       r_mem    [LANES][SKEW_DEPTH];
  logic [PW-1:0]    r_wp     [LANES];
  logic [PW-1:0]    r_rp     [LANES];
  logic [LANES-1:0] r_lock, r_ph;
  logic [LANES-1:0] w_match, w_new, w_wr, w_full, w_empty, w_lock_nx;
  logic             r_par;
  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             w_hunt, w_active, w_pop, w_ovf;

`ifdef SYNC_1BIT_TOL_EN
  function automatic logic f_one_bit(input logic [7:0] x);
    return (x != '0) && ((x & (x - 8'd1)) == '0);
  endfunction
`endif

  always_comb begin
    w_hunt   = (r_state == ST_HUNT) || (r_state == ST_ALIGN);
    w_active = (r_state == ST_ALIGN) || (r_state == ST_STREAM);
    for (int unsigned k = 0; k < LANES; k++) begin
      w_win_nx[k] = {nib_i[4*k +: 4], r_win[k][15:4]};
      // Capture from the window as it is updated at this edge, so the byte after sync lands whole.
      w_wdata[k]  = w_win_nx[k][r_off[k] +: 8];
      w_match[k]  = 1'b0;
      w_moff[k]   = '0;
      for (int unsigned o = 0; o < 4; o++) begin
        if (!w_match[k] && (r_win[k][o +: 8] == SYNC_BYTE)) begin
          w_match[k] = 1'b1;
          w_moff[k]  = 2'(o);
        end
      end
`ifdef SYNC_1BIT_TOL_EN
      for (int unsigned o = 0; o < 4; o++) begin
        if (!w_match[k] && f_one_bit(r_win[k][o +: 8] ^ SYNC_BYTE)) begin
          w_match[k] = 1'b1;
          w_moff[k]  = 2'(o);
        end
      end
`endif
      w_new[k]   = w_hunt && !r_lock[k] && w_match[k];
      w_empty[k] = (r_wp[k] == r_rp[k]);
      w_full[k]  = ((r_wp[k] - r_rp[k]) == PW'(SKEW_DEPTH));
      w_wr[k]    = w_active && r_lock[k] && (r_par != r_ph[k]);
    end
    w_lock_nx = r_lock | w_new;
    w_pop     = w_active && !(|w_empty);
    w_ovf     = (r_state == ST_STREAM) && (|(w_wr & w_full)) && !w_pop;
  end

  always_ff @(posedge sync_mipi_clk_2) begin
    if (reset || stop) begin
      r_par      <= 1'b0;
      r_lock     <= '0;
      r_ph       <= '0;
      r_state    <= ST_HUNT;
      r_cnt      <= '0;
      byte_o     <= '0;
      byte_valid <= 1'b0;
      locked     <= 1'b0;
      sync_err   <= 1'b0;
      for (int unsigned k = 0; k < LANES; k++) begin
        r_win[k] <= '0;
        r_off[k] <= '0;
        r_wp[k]  <= '0;
        r_rp[k]  <= '0;
      end
    end else begin
      r_par      <= ~r_par;
      byte_valid <= w_pop;
      for (int unsigned k = 0; k < LANES; k++) begin
        r_win[k] <= w_win_nx[k];
        if (w_new[k]) begin
          r_lock[k] <= 1'b1;
          r_off[k]  <= w_moff[k];
          r_ph[k]   <= r_par;
        end
        // While still aligning, an early lane's write into a full FIFO is dropped, not an error.
        if (w_wr[k] && (!w_full[k] || w_pop)) begin
          r_mem[k][r_wp[k][AW-1:0]] <= w_wdata[k];
          r_wp[k] <= r_wp[k] + PW'(1);
        end
        if (w_pop) begin
          r_rp[k]         <= r_rp[k] + PW'(1);
          byte_o[8*k +: 8] <= r_mem[k][r_rp[k][AW-1:0]];
        end
      end
      case (r_state)
        ST_HUNT: begin
          if (|w_new) begin
            r_cnt <= '0;
            if (&w_lock_nx) begin
              r_state <= ST_STREAM;
              locked  <= 1'b1;
            end else begin
              r_state <= ST_ALIGN;
            end
          end
        end
        ST_ALIGN: begin
          if (&w_lock_nx) begin
            r_state <= ST_STREAM;
            locked  <= 1'b1;
          end else if (r_cnt == CW'(SYNC_TIMEOUT - 1)) begin
            r_state  <= ST_ERROR;
            sync_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_STREAM: begin
          if (w_ovf) begin
            r_state  <= ST_ERROR;
            locked   <= 1'b0;
            sync_err <= 1'b1;
          end
        end
        ST_ERROR: ;
        default: r_state <= ST_HUNT;
      endcase
    end
  end

  assign lane_locked = r_lock;

endmodule

// File: tb/tb_mipi_lane_deskew_aligner.sv
// Scoreboard bench for mipi_lane_deskew_aligner (LANES=2, SKEW_DEPTH=4, SYNC_TIMEOUT=16).
module tb_mipi_lane_deskew_aligner;
  logic        clk = 1'b0;
  logic        reset;
  logic        stop;
  logic [7:0]  nib_i;
  logic [15:0] byte_o;
  logic        byte_valid;
  logic [1:0]  lane_locked;
  logic        locked;
  logic        sync_err;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_q [$];
  bit          q0 [$];
  bit          q1 [$];
  bit          allow_idle;
  logic [15:0] idle_val;

  mipi_lane_deskew_aligner #(
    .LANES(2), .SKEW_DEPTH(4), .SYNC_BYTE(8'hB8), .SYNC_TIMEOUT(16)
  ) dut (
    .sync_mipi_clk_2(clk), .reset(reset), .stop(stop), .nib_i(nib_i),
    .byte_o(byte_o), .byte_valid(byte_valid), .lane_locked(lane_locked),
    .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (byte_valid) begin
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("byte_o", 32'(byte_o), 32'(e));
        end else if (allow_idle) begin
          chk("idle_byte_o", 32'(byte_o), 32'(idle_val));
        end else begin
          chk("unexpected_byte_valid", 32'(byte_valid), 32'(0));
        end
      end
    end
  endtask

  task automatic push_byte(input int lane, input logic [7:0] b);
    for (int i = 0; i < 8; i++)
      if (lane == 0) q0.push_back(b[i]); else q1.push_back(b[i]);
  endtask

  task automatic push_zeros(input int lane, input int n);
    for (int i = 0; i < n; i++)
      if (lane == 0) q0.push_back(1'b0); else q1.push_back(1'b0);
  endtask

  task automatic step();
    logic [3:0] n0, n1;
    for (int i = 0; i < 4; i++) begin
      n0[i] = (q0.size() != 0) ? q0.pop_front() : 1'b0;
      n1[i] = (q1.size() != 0) ? q1.pop_front() : 1'b0;
    end
    nib_i = {n1, n0};
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    stop  = 1'b0;
    q0.delete();
    q1.delete();
    exp_q.delete();
    allow_idle = 1'b1;
    idle_val   = 16'h0000;
    step();
    step();
    chk("rst_byte_o", 32'(byte_o), 32'(0));
    chk("rst_byte_valid", 32'(byte_valid), 32'(0));
    chk("rst_lane_locked", 32'(lane_locked), 32'(0));
    chk("rst_locked_err", 32'({locked, sync_err}), 32'(0));
    reset = 1'b0;
  endtask

  task automatic wait_lock(input int bound);
    int n;
    n = 0;
    while (lane_locked == 2'b00 && n < bound) begin
      step();
      n++;
    end
    chk("lock_seen", 32'(lane_locked != 2'b00), 32'(1));
  endtask

  task automatic std_burst();
    push_byte(0, 8'hB8); push_byte(0, 8'h11); push_byte(0, 8'h22);
    push_byte(1, 8'hB8); push_byte(1, 8'h33); push_byte(1, 8'h44);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    stop  = 1'b0;
    nib_i = '0;
    allow_idle = 1'b1;
    idle_val   = '0;
    fork
      monitor();
    join_none
    @(negedge clk);

    // Test 1: aligned lanes, offset 0, 2-cycle latency from lock to first byte_valid
    do_reset();
    exp_q.push_back(16'h3311); exp_q.push_back(16'h4422);
    std_burst();
    wait_lock(20);
    chk("t1_lane_locked", 32'(lane_locked), 32'(2'b11));
    chk("t1_locked", 32'(locked), 32'(1));
    chk("t1_valid_at_lock", 32'(byte_valid), 32'(0));
    step();
    chk("t1_valid_lock+1", 32'(byte_valid), 32'(0));
    step();
    chk("t1_valid_lock+2", 32'(byte_valid), 32'(1));
    steps(12);
    chk("t1_drained", 32'(exp_q.size()), 32'(0));
    chk("t1_sync_err", 32'(sync_err), 32'(0));

    // Test 2: lane1 delayed by 19 bits and by 28 bits (latter keeps lane0 FIFO full while popping)
    for (int d = 0; d < 2; d++) begin
      do_reset();
      exp_q.push_back(16'h3311); exp_q.push_back(16'h4422);
      push_byte(0, 8'hB8); push_byte(0, 8'h11); push_byte(0, 8'h22);
      push_zeros(1, (d == 0) ? 19 : 28);
      push_byte(1, 8'hB8); push_byte(1, 8'h33); push_byte(1, 8'h44);
      steps(40);
      chk("t2_drained", 32'(exp_q.size()), 32'(0));
      chk("t2_locked", 32'(locked), 32'(1));
      chk("t2_lane_locked", 32'(lane_locked), 32'(2'b11));
      chk("t2_sync_err", 32'(sync_err), 32'(0));
    end

    // Test 3: lane1 never syncs -> timeout exactly 16 cycles after lane0 lock
    do_reset();
    allow_idle = 1'b0;
    push_byte(0, 8'hB8); push_byte(0, 8'h11); push_byte(0, 8'h22);
    wait_lock(20);
    chk("t3_lane_locked", 32'(lane_locked), 32'(2'b01));
    steps(15);
    chk("t3_err_at_15", 32'(sync_err), 32'(0));
    step();
    chk("t3_err_at_16", 32'(sync_err), 32'(1));
    chk("t3_locked", 32'(locked), 32'(0));
    steps(4);
    chk("t3_err_sticky", 32'(sync_err), 32'(1));

    // Test 4: 5-byte skew overflows lane0 FIFO one cycle after STREAM is entered
    do_reset();
    allow_idle = 1'b0;
    push_byte(0, 8'hB8);
    for (int i = 1; i <= 8; i++) push_byte(0, 8'(i));
    push_zeros(1, 40);
    push_byte(1, 8'hB8);
    for (int i = 1; i <= 8; i++) push_byte(1, 8'(8'h10 + i));
    wait_lock(20);
    chk("t4_lane_locked", 32'(lane_locked), 32'(2'b01));
    steps(10);
    chk("t4_locked_pre", 32'(locked), 32'(1));
    chk("t4_err_pre", 32'(sync_err), 32'(0));
    step();
    chk("t4_err_post", 32'(sync_err), 32'(1));
    chk("t4_locked_post", 32'(locked), 32'(0));
    steps(4);

    // Test 5: stop mid-stream clears everything; a fresh burst relocks
    do_reset();
    idle_val = 16'h7777;
    exp_q.push_back(16'h3311); exp_q.push_back(16'h4422);
    std_burst();
    for (int i = 0; i < 10; i++) begin
      push_byte(0, 8'h77);
      push_byte(1, 8'h77);
    end
    steps(12);
    chk("t5_drained", 32'(exp_q.size()), 32'(0));
    chk("t5_byte_pre_stop", 32'(byte_o), 32'(16'h7777));
    chk("t5_locked_pre_stop", 32'(locked), 32'(1));
    stop = 1'b1;
    q0.delete();
    q1.delete();
    step();
    stop = 1'b0;
    chk("t5_byte_o_clr", 32'(byte_o), 32'(0));
    chk("t5_valid_clr", 32'(byte_valid), 32'(0));
    chk("t5_lane_locked_clr", 32'(lane_locked), 32'(0));
    chk("t5_locked_err_clr", 32'({locked, sync_err}), 32'(0));
    idle_val = 16'h0000;
    exp_q.push_back(16'h6655);
    push_byte(0, 8'hB8); push_byte(0, 8'h55);
    push_byte(1, 8'hB8); push_byte(1, 8'h66);
    steps(14);
    chk("t5_relocked", 32'(locked), 32'(1));
    chk("t5_relock_drained", 32'(exp_q.size()), 32'(0));

    // Test 6: sync byte B9 (one bit off)
    do_reset();
    push_byte(0, 8'hB9); push_byte(0, 8'h11); push_byte(0, 8'h22);
    push_byte(1, 8'hB9); push_byte(1, 8'h33); push_byte(1, 8'h44);
`ifdef SYNC_1BIT_TOL_EN
    exp_q.push_back(16'h3311); exp_q.push_back(16'h4422);
    steps(20);
    chk("t6_lane_locked", 32'(lane_locked), 32'(2'b11));
    chk("t6_locked", 32'(locked), 32'(1));
    chk("t6_drained", 32'(exp_q.size()), 32'(0));
`else
    allow_idle = 1'b0;
    steps(20);
    chk("t6_lane_locked", 32'(lane_locked), 32'(0));
    chk("t6_locked", 32'(locked), 32'(0));
    chk("t6_sync_err", 32'(sync_err), 32'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
